// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_pkg: shared types and constants for the 4:1 mux scan sequencer.
//   state_t : sequencer states IDLE / SCAN / DONE
//   NUM_CH  : number of mux channels scanned
//   SEL_W   : width of the mux select (and channel index)
//   chan_t  : channel index type
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam chan_t LAST_CH = chan_t'(NUM_CH - 1);

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: bundles the scan request, the mux feedback, the
// select lines and the scan results.
//   start   : scan request (into sequencer)
//   mux_out : output of the downstream 4:1 mux (into sequencer)
//   s1, s0  : mux select lines (from sequencer)
//   busy    : scan in progress, accept edge through DONE cycle
//   done    : one-cycle pulse, snapshot complete
//   sample  : per-channel captured mux_out values
//   glitch  : sticky pre-sample/sample mismatch (only with MUX_SCAN_DEGLITCH_EN)
// Modports: master = sequencer side, slave = requester / mux side.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              mux_out;
  logic              s1;
  logic              s0;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] sample;
`ifdef MUX_SCAN_DEGLITCH_EN
  logic              glitch;

  modport master (input start, input mux_out,
                  output s1, output s0, output busy, output done,
                  output sample, output glitch);
  modport slave  (output start, output mux_out,
                  input s1, input s0, input busy, input done,
                  input sample, input glitch);
`else
  modport master (input start, input mux_out,
                  output s1, output s0, output busy, output done,
                  output sample);
  modport slave  (output start, output mux_out,
                  input s1, input s0, input busy, input done,
                  input sample);
`endif

endinterface

// File: rtl/mux_scan_sequencer_timer.sv
// mux_scan_timer: loadable 4-bit down-counter timing the settle interval of
// each channel. Load has priority over enable; the count saturates at zero.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load load_val
//   load_val : reload value
//   en       : decrement while non-zero
//   zero     : count is zero
//   count    : current count value
module mux_scan_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero,
  output logic [3:0] count
);

  logic [3:0] cnt_r;

  // down-counter with load priority and saturation at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero  = (cnt_r == 4'd0);
  assign count = cnt_r;

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the 4:1 mux select through channels 0..3, holds
// each for SETTLE+1 cycles, captures mux_out into sample[channel] at the end
// of each hold and pulses done once the 4-bit snapshot is complete.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mux_scan_sequencer_if.master (start, mux_out, s1, s0, busy, done,
//         sample, and glitch when MUX_SCAN_DEGLITCH_EN is defined)
// Parameter SETTLE (0..15): extra hold cycles per channel.
// Optional macro MUX_SCAN_DEGLITCH_EN adds a pre-sample one cycle before each
// capture and a sticky glitch flag; it requires SETTLE >= 1.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_scan_sequencer_if.master  bus
);

  if ((SETTLE < 0) || (SETTLE > 15)) begin : g_settle_range
    $error("mux_scan_sequencer: SETTLE must be within 0..15");
  end

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t            state_r;
  chan_t             chan_r;
  chan_t             sel_r;
  logic              busy_r;
  logic              done_r;
  logic [NUM_CH-1:0] sample_r;

  logic              accept_s;
  logic              last_s;
  logic              tmr_load_s;
  logic              tmr_en_s;
  logic              tmr_zero_s;
  logic [3:0]        tmr_count_s;

  // start is only honoured in IDLE; the timer reloads on accept and on each
  // channel advance, and counts down only while scanning
  always_comb begin
    accept_s   = 1'b0;
    last_s     = (chan_r == LAST_CH);
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    if (state_r == IDLE) begin
      accept_s   = bus.start;
      tmr_load_s = bus.start;
    end else if (state_r == SCAN) begin
      tmr_en_s   = 1'b1;
      tmr_load_s = tmr_zero_s && !last_s;
    end else begin
      tmr_en_s   = 1'b0;
    end
  end

  mux_scan_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (SETTLE_V),
    .en       (tmr_en_s),
    .zero     (tmr_zero_s),
    .count    (tmr_count_s)
  );

  // scan state machine with registered select, busy, done and snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      chan_r   <= '0;
      sel_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sample_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          sel_r  <= '0;
          chan_r <= '0;
          if (accept_s) begin
            state_r <= SCAN;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (tmr_zero_s) begin
            sample_r[chan_r] <= bus.mux_out;
            if (last_s) begin
              // select stays on the last channel through DONE
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              chan_r <= chan_r + 2'd1;
              sel_r  <= chan_r + 2'd1;
            end
          end else begin
            chan_r <= chan_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          sel_r   <= '0;
          chan_r  <= '0;
        end
        default: begin
          state_r <= IDLE;
          chan_r  <= '0;
          sel_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1     = sel_r[1];
  assign bus.s0     = sel_r[0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.sample = sample_r;

`ifdef MUX_SCAN_DEGLITCH_EN
  if (SETTLE == 0) begin : g_deglitch_settle
    $error("mux_scan_sequencer: MUX_SCAN_DEGLITCH_EN requires SETTLE >= 1");
  end

  logic pre_r;
  logic glitch_r;

  // pre-sample one cycle before capture; flag any change at capture, sticky
  // until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r    <= 1'b0;
      glitch_r <= 1'b0;
    end else if (accept_s) begin
      pre_r    <= pre_r;
      glitch_r <= 1'b0;
    end else if (state_r == SCAN) begin
      if (tmr_count_s == 4'd1) begin
        pre_r <= bus.mux_out;
      end else begin
        pre_r <= pre_r;
      end
      if (tmr_zero_s && (bus.mux_out != pre_r)) begin
        glitch_r <= 1'b1;
      end else begin
        glitch_r <= glitch_r;
      end
    end else begin
      pre_r    <= pre_r;
      glitch_r <= glitch_r;
    end
  end

  assign bus.glitch = glitch_r;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: two sequencers (SETTLE=1 and SETTLE=0), each fed by
// a behavioural 4:1 mux, driven by a directed prefix followed by randomized
// start / mux-input / reset stimulus. Expected outputs come from a model that
// tracks only the number of edges elapsed since the accepted start.
`timescale 1ns/1ps
module tb_mux_scan_sequencer;

  localparam int SA = 1;
  localparam int SB = 0;
  localparam int NCYC = 600;

  logic clk;
  logic rst;
  logic [3:0] ia;
  logic [3:0] ib;

  int pass_cnt;
  int total_cnt;

  // model state: edges since accept (-1 when idle) and expected snapshot
  int         na;
  int         nb;
  logic [3:0] sa;
  logic [3:0] sb;

  mux_scan_sequencer_if ifa ();
  mux_scan_sequencer_if ifb ();

  mux_scan_sequencer #(.SETTLE(SA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_scan_sequencer #(.SETTLE(SB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // behavioural 4:1 muxes downstream of each sequencer
  assign ifa.mux_out = ia[{ifa.s1, ifa.s0}];
  assign ifb.mux_out = ib[{ifb.s1, ifb.s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance the model by one clock edge
  task automatic step(input int s, input logic st, input logic [3:0] iv,
                      inout int n, inout logic [3:0] smp);
    if (n < 0) begin
      if (st) n = 0;
    end else begin
      n = n + 1;
      for (int k = 0; k < 4; k++) begin
        if (n == (k + 1) * (s + 1)) smp[k] = iv[k];
      end
      if (n > 4 * s + 4) n = -1;
    end
  endtask

  function automatic logic [1:0] exp_sel(input int s, input int n);
    if (n < 0) return 2'd0;
    else if (n >= 4 * s + 4) return 2'd3;
    else return 2'(n / (s + 1));
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "a_busy"},   {7'd0, ifa.busy},            {7'd0, na >= 0});
    chk({pfx, "a_done"},   {7'd0, ifa.done},            {7'd0, na == 4 * SA + 4});
    chk({pfx, "a_sel"},    {6'd0, ifa.s1, ifa.s0},      {6'd0, exp_sel(SA, na)});
    chk({pfx, "a_sample"}, {4'd0, ifa.sample},          {4'd0, sa});
    chk({pfx, "b_busy"},   {7'd0, ifb.busy},            {7'd0, nb >= 0});
    chk({pfx, "b_done"},   {7'd0, ifb.done},            {7'd0, nb == 4 * SB + 4});
    chk({pfx, "b_sel"},    {6'd0, ifb.s1, ifb.s0},      {6'd0, exp_sel(SB, nb)});
    chk({pfx, "b_sample"}, {4'd0, ifb.sample},          {4'd0, sb});
  endtask

  // inputs seen at edge c: directed scenario first, random afterwards
  task automatic set_inputs(input int c);
    if (c < 24) begin
      ia = 4'b1010;
      ib = 4'b0110;
      ifa.start = (c == 0) || (c == 3);
      ifb.start = (c < 12);
    end else if (c < 40) begin
      ifa.start = (c == 24);
      ifb.start = 1'b0;
    end else begin
      ia = 4'($urandom_range(0, 15));
      ib = 4'($urandom_range(0, 15));
      ifa.start = ($urandom_range(0, 3) == 0);
      ifb.start = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    na = -1; nb = -1;
    sa = 4'd0; sb = 4'd0;
    ia = 4'd0; ib = 4'd0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_");
    @(negedge clk);
    rst = 1'b0;
    set_inputs(0);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      step(SA, ifa.start, ia, na, sa);
      step(SB, ifb.start, ib, nb, sb);
      #1;
      check_all("");
      // directed mid-scan reset at E5 of the second SETTLE=1 scan, then rare random ones
      if ((c == 29) || ((c > 40) && ($urandom_range(0, 59) == 0))) begin
        #2;
        rst = 1'b1;
        na = -1; nb = -1;
        sa = 4'd0; sb = 4'd0;
        #1;
        check_all("arst_");
        #1;
        rst = 1'b0;
      end
      set_inputs(c + 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream control stage for the 4:1 gate-level select mux. It generates the mux select lines s1/s0 and steps through channels 0..3, waiting a settle interval on each. It samples the mux output once per channel into a 4-bit snapshot and reports scan completion with a one-cycle done pulse. A scan starts from a single start request; a new request is not accepted until the current scan is complete.

Parameters:
SETTLE, 1, extra cycles each select value is held before its sample is taken; legal range 0..15.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a scan; sampled only in IDLE.
mux_out  input  1  output of the downstream 4:1 mux.
s1  output  1  select MSB to the mux.
s0  output  1  select LSB to the mux.
busy  output  1  high from the edge that accepts start through the DONE cycle.
done  output  1  one-cycle pulse; snapshot is complete.
sample  output  4  sample[k] holds the mux_out value captured while {s1,s0}==k.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, {s1,s0}=2'b00, busy=0, done=0, sample=4'b0000, channel=0, counter=0.
- State machine has three states: IDLE, SCAN, DONE.
- IDLE, start=1 at edge E0: go to SCAN with channel=0, counter=SETTLE, busy=1.
- IDLE, start=0: stay in IDLE.
- SCAN, counter!=0: decrement counter.
- SCAN, counter==0: set sample[channel] <= mux_out.
  - channel<3: increment channel and reload counter=SETTLE.
  - channel==3: go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. {s1,s0} returns to 00 on entry to IDLE.
- Select outputs: {s1,s0} equals channel while in SCAN. Both are registered outputs, with no combinational path from start.
- Timing:
  - Each channel is held for SETTLE+1 cycles.
  - The channel k capture happens at edge E((k+1)*(SETTLE+1)).
  - done is high between edges E(4*SETTLE+4) and E(4*SETTLE+5).
  - Minimum start-to-start spacing is 4*SETTLE+6 cycles.
- start while busy (SCAN or DONE) is ignored, not queued.
- start held high continuously: the next scan is accepted in the first IDLE cycle after DONE.
- sample bits update incrementally during a scan. The snapshot is coherent only when done=1, and it holds until overwritten by the next scan.
- SETTLE=0: one cycle per channel; done at E4.
- Reset asserted mid-scan:
  - All outputs return to their reset values immediately, without waiting for clk.
  - The partial snapshot is discarded (sample=0).
  - After rst deasserts, the block sits in IDLE waiting for start.
- channel is 2 bits and never wraps inside a scan; the transition from channel 3 always goes to DONE.

Optional Feature:
MUX_SCAN_DEGLITCH_EN
- Defined:
  - Adds output port glitch (1 bit, reset 0).
  - In SCAN, when counter==1, mux_out is stored in a pre-sample flop.
  - At counter==0, if mux_out differs from the pre-sample, a sticky mismatch flag is set.
  - glitch is valid while done=1 and holds until the next accepted start clears it.
  - SETTLE must be >=1; SETTLE=0 is an elaboration error.
- Undefined: the glitch port, the pre-sample flop and the mismatch flag are absent. Behaviour is otherwise identical.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - constant NUM_CH=4;
  - constant SEL_W=2;
  - typedef chan_t (logic [SEL_W-1:0]).
- One sub-module, mux_scan_timer: a loadable 4-bit down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Used by the SCAN state to time each channel.

Test Plan:
- SETTLE=1, mux_out driven by a behavioural mux with inputs i={i3,i2,i1,i0}=4'b1010, start pulsed at E0:
  - {s1,s0} is 00,01,10,11 for 2 cycles each;
  - done pulses between E8 and E9 with sample=4'b1010;
  - busy high from E0 to E9.
- SETTLE=0, i=4'b0110: done at E4, sample=4'b0110. Then start held high: the second scan is accepted at E6 and its done occurs at E10.
- start pulsed again at E3 of a SETTLE=1 scan: ignored; the done timing and sample of the first scan are unchanged, and no second scan runs.
- rst asserted asynchronously mid-cycle at E5 of a SETTLE=1 scan:
  - s1=s0=0, busy=0 and sample=0 before the next clk edge;
  - no done pulse;
  - a fresh start after release scans normally.
- With MUX_SCAN_DEGLITCH_EN, SETTLE=2, i2 toggling between the pre-sample and sample edges of channel 2: glitch=1 during done, sample[2] equals the later value, and glitch clears at the next accepted start.
- With MUX_SCAN_DEGLITCH_EN, all inputs stable at 4'b1111: glitch=0 and sample=4'b1111 at done.
